n_bit_cbs_seq: RTL



---
 rtl/n_bit_cbs_seq_pkg.sv | 22 ++
 rtl/n_bit_cbs_seq_block4.sv | 39 +++
 rtl/n_bit_cbs_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/n_bit_cbs_seq_pkg.sv
// ---------------------------------------------------------------------------
// cbs_pkg: shared definitions for the block-serial carry-bypass subtractor.
//   BLK_W          width of one carry-bypass block (bits)
//   state_t        sequencer states
//   cbs_blk_count  number of BLK_W-bit blocks needed for a given width
// ---------------------------------------------------------------------------
package cbs_pkg;

    localparam int unsigned BLK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Block count for an operand width that is a multiple of BLK_W.
    function automatic int unsigned cbs_blk_count(input int unsigned width);
        return width / BLK_W;
    endfunction

endpackage

// File: rtl/n_bit_cbs_seq_block4.sv
// ---------------------------------------------------------------------------
// cbs_block4: combinational 4-bit carry-bypass adder block.
//   a4     first operand nibble
//   bn4    second operand nibble (already inverted for subtraction)
//   c_in   carry into the block
//   sum4   4-bit sum
//   c_out  carry out; equals c_in when every bit propagates
//   skip   1 when all four propagate bits are set (bypass taken)
// ---------------------------------------------------------------------------
module cbs_block4
    import cbs_pkg::*;
(
    input  logic [BLK_W-1:0] a4,
    input  logic [BLK_W-1:0] bn4,
    input  logic             c_in,
    output logic [BLK_W-1:0] sum4,
    output logic             c_out,
    output logic             skip
);

    logic [BLK_W-1:0] p;
    logic [BLK_W-1:0] g;
    logic [BLK_W:0]   c;

    // Generate/propagate ripple with a bypass mux on the block carry-out.
    always_comb begin
        p     = a4 ^ bn4;
        g     = a4 & bn4;
        c     = '0;
        c[0]  = c_in;
        for (int i = 0; i < int'(BLK_W); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum4  = p ^ c[BLK_W-1:0];
        skip  = &p;
        c_out = skip ? c_in : c[BLK_W];
    end

endmodule

// File: rtl/n_bit_cbs_seq.sv
// ---------------------------------------------------------------------------
// n_bit_cbs_seq: block-serial carry-bypass subtractor, diff = a - b - b_in.
// Processes one 4-bit block per clock as a + ~b + ~b_in; the result is ready
// NBLK clocks after the operands are accepted.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   block can accept operands (idle and not in reset)
//   a, b       minuend / subtrahend
//   b_in       borrow-in
//   out_valid  result valid
//   out_ready  consumer accepts result
//   diff       a - b - b_in mod 2^WIDTH
//   b_out      borrow-out (unsigned a < b + b_in)
//   ovf        two's-complement overflow
//   skip_cnt   number of bypassed blocks (only with CBS_SKIP_CNT_EN)
//
// Build option: define CBS_SKIP_CNT_EN to add the skip_cnt output.
// ---------------------------------------------------------------------------
module n_bit_cbs_seq
    import cbs_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NBLK  = cbs_blk_count(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
`ifdef CBS_SKIP_CNT_EN
    ,
    output logic [$clog2(NBLK+1)-1:0] skip_cnt
`endif
);

    localparam int unsigned KW = (NBLK > 1) ? $clog2(NBLK) : 1;
`ifdef CBS_SKIP_CNT_EN
    localparam int unsigned SW = $clog2(NBLK + 1);
`endif

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bn_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             ovf_q;
    logic             out_valid_q;
`ifdef CBS_SKIP_CNT_EN
    logic [SW-1:0]    skip_q;
`endif

    logic [BLK_W-1:0] sum4_c;
    logic             c_out_c;
    logic             skip_c;
    logic             c_msb_in_c;
    logic             last_blk_c;
    logic [WIDTH-1:0] diff_shift_c;

    // Operands are shifted right each RUN edge, so the active block is always
    // the low nibble and no variable part-select is needed.
    cbs_block4 u_blk (
        .a4    (a_q[BLK_W-1:0]),
        .bn4   (bn_q[BLK_W-1:0]),
        .c_in  (carry_q),
        .sum4  (sum4_c),
        .c_out (c_out_c),
        .skip  (skip_c)
    );

    // Carry into the operand MSB, recovered from the MSB sum bit of the last block.
    assign c_msb_in_c = a_q[BLK_W-1] ^ bn_q[BLK_W-1] ^ sum4_c[BLK_W-1];
    assign last_blk_c = (k_q == KW'(NBLK - 1));

    // Result shifts in from the top; after NBLK edges block k sits at diff[4k+3:4k].
    if (WIDTH > BLK_W) begin : g_wide
        assign diff_shift_c = {sum4_c, diff_q[WIDTH-1:BLK_W]};
    end else begin : g_single
        assign diff_shift_c = sum4_c;
    end

    // Sequencer, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bn_q        <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            diff_q      <= '0;
            b_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CBS_SKIP_CNT_EN
            skip_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        bn_q    <= ~b;
                        carry_q <= ~b_in;
                        k_q     <= '0;
`ifdef CBS_SKIP_CNT_EN
                        skip_q  <= '0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> BLK_W;
                    bn_q    <= bn_q >> BLK_W;
                    carry_q <= c_out_c;
                    diff_q  <= diff_shift_c;
                    k_q     <= k_q + KW'(1);
`ifdef CBS_SKIP_CNT_EN
                    if (skip_c) begin
                        skip_q <= skip_q + SW'(1);
                    end
`endif
                    if (last_blk_c) begin
                        b_out_q     <= ~c_out_c;
                        ovf_q       <= c_msb_in_c ^ c_out_c;
                        out_valid_q <= 1'b1;
                        k_q         <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Ready drops immediately with reset so nothing is accepted on a reset edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;
`ifdef CBS_SKIP_CNT_EN
    assign skip_cnt  = skip_q;
`endif

endmodule
